// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU; one operation in flight at a time.
// Latency: request accepted at edge T, response valid from edge T+1 (EXEC then RESP), issue every 3 cycles minimum.
// Backpressure: req_ready drops outside IDLE; the response is held stable until the owner asserts rsp_ready.
module alu_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_sel,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_sel,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  input  logic         alu_sign,
  input  logic         alu_carry,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [3:0]   alu_sel_q, alu_sel_d;
  logic [N-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;
  logic         owner_q, owner_d;
  // last_q holds the requester granted most recently; the other one wins a tie.
  logic         last_q, last_d;

  logic         grant_idx;
  logic         req_fire;
  logic         rsp_fire;

  // Arbitration winner and the request-side handshake; ready is gated by reset so nothing is seen as accepted while held in reset.
  always_comb begin
    grant_idx = 1'b0;
    case (req_valid)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_q;
      default: grant_idx = 1'b0;
    endcase
    req_ready = 2'b00;
    if (state_q == IDLE && rst) begin
      req_ready[grant_idx] = req_valid[grant_idx];
    end
    req_fire = |(req_valid & req_ready);
  end

  // Response side: only the owner's bit is ever raised, so the non-owner's rsp_ready drops out of the AND.
  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == RESP) begin
      rsp_valid[owner_q] = 1'b1;
    end
    rsp_fire = |(rsp_valid & rsp_ready);
  end

  // Next-state and datapath loads for the IDLE -> EXEC -> RESP cycle.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    owner_d      = owner_q;
    last_d       = last_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          alu_a_d   = grant_idx ? req1_a   : req0_a;
          alu_b_d   = grant_idx ? req1_b   : req0_b;
          alu_sel_d = grant_idx ? req1_sel : req0_sel;
          owner_d   = grant_idx;
          last_d    = grant_idx;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // The ALU has had a full cycle on the registered operands; capture once and never again.
        rsp_result_d = alu_result;
        rsp_flags_d  = {alu_zero, alu_overflow, alu_sign, alu_carry};
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All state; reset abandons any operation in flight and re-arms requester 0 for the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached to the alu_* ports.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
// Expected values are hand-computed constants per step.
module tb_alu_arbiter;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_sel, req1_sel;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [N-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [N-1:0] alu_a, alu_b;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_result;
  logic         alu_zero, alu_overflow, alu_sign, alu_carry;
  logic         busy;

  int vectors = 0;
  int errors  = 0;

  alu_arbiter #(.N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_a       (req0_a),
    .req0_b       (req0_b),
    .req0_sel     (req0_sel),
    .req1_a       (req1_a),
    .req1_b       (req1_b),
    .req1_sel     (req1_sel),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_flags    (rsp_flags),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .alu_sign     (alu_sign),
    .alu_carry    (alu_carry),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: 0010 add, 0110 subtract (a + ~b + 1), anything else AND.
  logic [N:0] alu_wide;
  always_comb begin
    alu_wide     = '0;
    alu_overflow = 1'b0;
    case (alu_sel)
      4'b0010: begin
        alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[N-1] == alu_b[N-1]) && (alu_wide[N-1] != alu_a[N-1]);
      end
      4'b0110: begin
        alu_wide     = {1'b0, alu_a} + {1'b0, ~alu_b} + {{N{1'b0}}, 1'b1};
        alu_overflow = (alu_a[N-1] != alu_b[N-1]) && (alu_wide[N-1] != alu_a[N-1]);
      end
      default: alu_wide = {1'b0, alu_a & alu_b};
    endcase
    alu_result = alu_wide[N-1:0];
    alu_carry  = alu_wide[N];
    alu_zero   = (alu_wide[N-1:0] == '0);
    alu_sign   = alu_wide[N-1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]   exp_grant;
    logic [N-1:0] exp_a;
    logic [N-1:0] exp_res;

    rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_a = '0; req1_b = '0; req1_sel = '0;
    #12;
    chk("rst_rsp_valid",  64'(rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("rst_rsp_flags",  64'(rsp_flags), 64'd0);
    chk("rst_alu_a",      64'(alu_a), 64'd0);
    chk("rst_alu_b",      64'(alu_b), 64'd0);
    chk("rst_alu_sel",    64'(alu_sel), 64'd0);
    chk("rst_busy",       64'(busy), 64'd0);
    step();
    rst = 1'b1;

    // req0 ADD 5+7, accepted in the first cycle after reset release.
    req_valid = 2'b01; req0_a = 32'd5; req0_b = 32'd7; req0_sel = 4'b0010; rsp_ready = 2'b01;
    #1;
    chk("add_req_ready", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b00;
    chk("add_exec_busy",  64'(busy), 64'd1);
    chk("add_exec_rdy",   64'(req_ready), 64'd0);
    chk("add_exec_rspv",  64'(rsp_valid), 64'd0);
    chk("add_alu_a",      64'(alu_a), 64'd5);
    chk("add_alu_b",      64'(alu_b), 64'd7);
    chk("add_alu_sel",    64'(alu_sel), 64'b0010);
    step();
    chk("add_rsp_valid",  64'(rsp_valid), 64'b01);
    chk("add_result",     64'(rsp_result), 64'd12);
    chk("add_flags",      64'(rsp_flags), 64'b0000);
    step();
    chk("add_done_busy",  64'(busy), 64'd0);
    chk("add_done_rspv",  64'(rsp_valid), 64'd0);

    // req1 SUB 3-3: zero result, carry set (no borrow).
    req_valid = 2'b10; req1_a = 32'd3; req1_b = 32'd3; req1_sel = 4'b0110; rsp_ready = 2'b10;
    #1;
    chk("sub_req_ready", 64'(req_ready), 64'b10);
    step();
    req_valid = 2'b00;
    chk("sub_exec_busy", 64'(busy), 64'd1);
    step();
    chk("sub_rsp_valid", 64'(rsp_valid), 64'b10);
    chk("sub_result",    64'(rsp_result), 64'd0);
    chk("sub_flags",     64'(rsp_flags), 64'b1001);
    chk("sub_resp_busy", 64'(busy), 64'd1);
    step();
    chk("sub_done_busy", 64'(busy), 64'd0);

    // Fresh reset, then both requesters valid for three rounds: grants 0,1,0.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    req0_a = 32'd1;  req0_b = 32'd2;  req0_sel = 4'b0010;
    req1_a = 32'd10; req1_b = 32'd20; req1_sel = 4'b0010;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int r = 0; r < 3; r++) begin
      exp_grant = (r == 1) ? 2'b10 : 2'b01;
      exp_a     = (r == 1) ? 32'd10 : 32'd1;
      exp_res   = (r == 1) ? 32'd30 : 32'd3;
      #1;
      chk($sformatf("rr%0d_req_ready", r), 64'(req_ready), 64'(exp_grant));
      step();
      chk($sformatf("rr%0d_alu_a", r), 64'(alu_a), 64'(exp_a));
      step();
      chk($sformatf("rr%0d_rsp_valid", r), 64'(rsp_valid), 64'(exp_grant));
      chk($sformatf("rr%0d_result", r), 64'(rsp_result), 64'(exp_res));
      step();
    end

    // Owner 0 stalls its response for 5 cycles while req1 waits; non-owner rsp_ready is ignored.
    req_valid = 2'b01; req0_a = 32'd100; req0_b = 32'd50; req0_sel = 4'b0010; rsp_ready = 2'b00;
    #1;
    chk("stall_req_ready", 64'(req_ready), 64'b01);
    step();
    req_valid = 2'b10; req1_a = 32'd7; req1_b = 32'd1; req1_sel = 4'b0110; rsp_ready = 2'b10;
    step();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_rsp_valid", c), 64'(rsp_valid), 64'b01);
      chk($sformatf("stall%0d_result", c), 64'(rsp_result), 64'd150);
      chk($sformatf("stall%0d_req_ready", c), 64'(req_ready), 64'b00);
      chk($sformatf("stall%0d_alu_a", c), 64'(alu_a), 64'd100);
      step();
    end
    rsp_ready = 2'b01;
    step();
    chk("release_req_ready", 64'(req_ready), 64'b10);
    rsp_ready = 2'b11;
    step();
    req_valid = 2'b00;
    chk("release_alu_a", 64'(alu_a), 64'd7);
    step();
    chk("release_rsp_valid", 64'(rsp_valid), 64'b10);
    chk("release_result",    64'(rsp_result), 64'd6);
    chk("release_flags",     64'(rsp_flags), 64'b0001);
    step();

    // Reset during EXEC abandons the operation.
    req_valid = 2'b01; req0_a = 32'd5; req0_b = 32'd7; req0_sel = 4'b0010; rsp_ready = 2'b01;
    step();
    chk("abort_exec_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy",      64'(busy), 64'd0);
    chk("abort_alu_a",     64'(alu_a), 64'd0);
    chk("abort_alu_sel",   64'(alu_sel), 64'd0);
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_req_ready", 64'(req_ready), 64'd0);
    chk("abort_result",    64'(rsp_result), 64'd0);
    req_valid = 2'b00;
    step();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("abort_quiet%0d", c), 64'(rsp_valid), 64'd0);
    end
    req_valid = 2'b01; req0_a = 32'd20; req0_b = 32'd22;
    step();
    req_valid = 2'b00;
    step();
    chk("post_rsp_valid", 64'(rsp_valid), 64'b01);
    chk("post_result",    64'(rsp_result), 64'd42);
    step();
    chk("post_busy",      64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: N, default 32, operand/result width of the shared ALU.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; clears all state immediately when 0.
REQ-004 req_valid  input  2  per-requester operation request (bit i = requester i).
REQ-005 req_ready  output  2  per-requester accept; handshake on req_valid[i] & req_ready[i].
REQ-006 req0_a, req0_b  input  N each  requester 0 operands.
REQ-007 req0_sel  input  4  requester 0 ALU select code.
REQ-008 req1_a, req1_b  input  N each  requester 1 operands.
REQ-009 req1_sel  input  4  requester 1 ALU select code.
REQ-010 rsp_valid  output  2  per-requester response valid.
REQ-011 rsp_ready  input  2  per-requester response accept.
REQ-012 rsp_result  output  N  captured ALU result, shared by both requesters.
REQ-013 rsp_flags  output  4  captured {zero, overflow, sign, carry}, MSB first.
REQ-014 alu_a, alu_b  output  N each  registered operands driven to the combinational ALU.
REQ-015 alu_sel  output  4  registered select driven to the ALU.
REQ-016 alu_result  input  N  ALU result.
REQ-017 alu_zero, alu_overflow, alu_sign, alu_carry  input  1 each  ALU flags.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 FSM states IDLE, EXEC, RESP; exactly one operation in flight.
REQ-020 IDLE: req_ready[i] = 1 combinationally only for the arbitration winner i, and only when req_valid[i]=1; both 0 in EXEC and RESP.
REQ-021 Arbitration: single valid wins; on tie, the requester not granted last wins; after reset requester 0 wins the first tie.
REQ-022 On handshake: alu_a/alu_b/alu_sel load the winner's operands/select, owner register and last-grant pointer update to winner, state -> EXEC.
REQ-023 EXEC lasts exactly one cycle; at its end rsp_result and rsp_flags load from ALU inputs, state -> RESP.
REQ-024 RESP: rsp_valid[owner]=1, other bit 0; rsp_result/rsp_flags/alu_* stay stable until rsp_ready[owner]=1.
REQ-025 Response handshake (rsp_valid[owner] & rsp_ready[owner]) -> IDLE next cycle; rsp_ready of the non-owner is ignored.
REQ-026 Latency: handshake at edge T -> rsp_valid high in cycle T+2; minimum issue interval 3 cycles.
REQ-027 req_valid asserted during EXEC/RESP is not accepted; it waits for IDLE with no loss (requester holds operands while valid).
REQ-028 Response handshake and a new req_valid in the same cycle: the new request is accepted no earlier than the following IDLE cycle.
REQ-029 req_valid dropped before handshake: no operation issued, no state change.
REQ-030 Select codes pass through unmodified; undefined codes are the ALU's concern, not rejected here.
REQ-031 rsp_flags and rsp_result are never recomputed after capture; changes on ALU inputs during RESP have no effect.

Reset
REQ-032 On rst=0: state IDLE, rsp_valid=0, rsp_result=0, rsp_flags=0, alu_a=alu_b=0, alu_sel=0, owner=0, pointer set so requester 0 wins the next tie, busy=0.
REQ-033 Reset in EXEC or RESP abandons the operation; no response is ever produced for it.
REQ-034 First acceptance possible in the first cycle after rst returns to 1.

Verification
REQ-035 req0 ADD: a=5, b=7, sel=0010, rsp_ready=1 -> rsp_valid[0] at T+2, result=12, zero=0, sign=0; rsp_valid[1]=0.
REQ-036 req1 SUB: a=3, b=3, sel=0110 -> rsp_valid[1] at T+2, result=0, zero flag=1, busy high T+1..T+3.
REQ-037 Both valid after reset, three back-to-back rounds -> grant order 0,1,0; each rsp_valid on the correct bit only.
REQ-038 rsp_ready[0]=0 for 5 cycles in RESP, req1 valid -> rsp_valid[0] held, result stable, req_ready=00; req1 accepted after release.
REQ-039 rst=0 asserted during EXEC -> all outputs 0 asynchronously, no rsp_valid after release; next request completes normally.
